// File: rtl/exception_controller_if.sv
// Bundle of MEM-stage, coprocessor0 and fetch-control signals around the exception controller.
// The controller is the slave; the pipeline/CP0 side is the master.
interface exception_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_valid;
    logic [DATA_WIDTH-1:0] mem_pc;
    logic                  exc_syscall;
    logic                  exc_illegal;
    logic                  exc_trap;
    logic                  exc_overflow;
    logic                  exc_eret;
    logic                  mem_drained;
    logic [DATA_WIDTH-1:0] cp0_status;
    logic [DATA_WIDTH-1:0] cp0_cause;
    logic [DATA_WIDTH-1:0] cp0_epc;
    logic [DATA_WIDTH-1:0] cp0_exception;
    logic [DATA_WIDTH-1:0] cp0_pc;
    logic                  stall;
    logic                  flush;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  busy;

    modport master (
        output mem_valid, mem_pc, exc_syscall, exc_illegal, exc_trap, exc_overflow,
               exc_eret, mem_drained, cp0_status, cp0_cause, cp0_epc,
        input  cp0_exception, cp0_pc, stall, flush, redirect_pc, busy
    );

    modport slave (
        input  mem_valid, mem_pc, exc_syscall, exc_illegal, exc_trap, exc_overflow,
               exc_eret, mem_drained, cp0_status, cp0_cause, cp0_epc,
        output cp0_exception, cp0_pc, stall, flush, redirect_pc, busy
    );
endinterface

// File: rtl/exception_controller.sv
// Exception/interrupt sequencer: arbitrates MEM-stage requests, drains the pipeline,
// pulses the encoded exception to CP0, then flushes and redirects fetch.
module exception_controller #(
    parameter int                 DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] VECTOR_NORMAL = 32'h8000_0180,
    parameter logic [DATA_WIDTH-1:0] VECTOR_BOOT   = 32'hBFC0_0380,
    parameter int unsigned        DRAIN_MAX     = 15
) (
    input logic                   clk,
    input logic                   rst_n,
    exception_controller_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_COMMIT,
        S_REDIRECT
    } state_t;

    typedef enum logic [2:0] {
        EXCEPT_NONE      = 3'd0,
        EXCEPT_INTERRUPT = 3'd1,
        EXCEPT_ILLEGAL   = 3'd2,
        EXCEPT_OVERFLOW  = 3'd3,
        EXCEPT_TRAP      = 3'd4,
        EXCEPT_SYSCALL   = 3'd5,
        EXCEPT_ERET      = 3'd6
    } exc_code_t;

    state_t                state_q, state_d;
    exc_code_t             code_q, req_code;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [7:0]            cnt_q;
    logic                  int_req;
    logic                  accept;

    // Interrupt is pending when IE=1, EXL=0 and any unmasked cause.IP bit is set.
    assign int_req = bus.cp0_status[0] & ~bus.cp0_status[1]
                   & (|(bus.cp0_cause[15:8] & bus.cp0_status[15:8]));

    always_comb begin
        if      (int_req)          req_code = EXCEPT_INTERRUPT;
        else if (bus.exc_illegal)  req_code = EXCEPT_ILLEGAL;
        else if (bus.exc_overflow) req_code = EXCEPT_OVERFLOW;
        else if (bus.exc_trap)     req_code = EXCEPT_TRAP;
        else if (bus.exc_syscall)  req_code = EXCEPT_SYSCALL;
        else if (bus.exc_eret)     req_code = EXCEPT_ERET;
        else                       req_code = EXCEPT_NONE;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_d           = state_q;
        accept            = 1'b0;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.cp0_exception = '0;
        bus.cp0_pc        = '0;
        bus.redirect_pc   = '0;
        unique case (state_q)
            S_IDLE: begin
                // Gated by rst_n so the combinational stall stays low while reset is held.
                if (rst_n && bus.mem_valid && (req_code != EXCEPT_NONE)) begin
                    accept    = 1'b1;
                    bus.stall = 1'b1;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                bus.stall = 1'b1;
                if (bus.mem_drained || (cnt_q == 8'(DRAIN_MAX - 1)))
                    state_d = S_COMMIT;
            end
            S_COMMIT: begin
                bus.stall         = 1'b1;
                bus.cp0_exception = DATA_WIDTH'(code_q);
                bus.cp0_pc        = pc_q;
                state_d           = S_REDIRECT;
            end
            S_REDIRECT: begin
                bus.stall = 1'b1;
                bus.flush = 1'b1;
                // EPC is read here, one edge after CP0 captured it during COMMIT.
                if (code_q == EXCEPT_ERET)
                    bus.redirect_pc = bus.cp0_epc;
                else
                    bus.redirect_pc = bus.cp0_status[22] ? VECTOR_BOOT : VECTOR_NORMAL;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= EXCEPT_NONE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                code_q <= req_code;
                pc_q   <= bus.mem_pc;
                cnt_q  <= '0;
            end else if (state_q == S_DRAIN) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_exception_controller.sv
// Randomized self-checking bench for exception_controller against a cycle-level
// reference derived from the arbitration and sequencing rules.
module tb_exception_controller;

    localparam int          DW        = 32;
    localparam int          DRAIN_MAX = 15;
    localparam logic [31:0] V_NORMAL  = 32'h8000_0180;
    localparam logic [31:0] V_BOOT    = 32'hBFC0_0380;

    localparam logic [31:0] C_NONE = 32'd0;
    localparam logic [31:0] C_INT  = 32'd1;
    localparam logic [31:0] C_ILL  = 32'd2;
    localparam logic [31:0] C_OVF  = 32'd3;
    localparam logic [31:0] C_TRAP = 32'd4;
    localparam logic [31:0] C_SYS  = 32'd5;
    localparam logic [31:0] C_ERET = 32'd6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    exception_controller_if #(.DATA_WIDTH(DW)) bus ();

    exception_controller #(
        .DATA_WIDTH   (DW),
        .VECTOR_NORMAL(V_NORMAL),
        .VECTOR_BOOT  (V_BOOT),
        .DRAIN_MAX    (DRAIN_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // flags = {illegal, overflow, trap, syscall, eret}
    function automatic logic [31:0] ref_code(input logic valid, input logic [4:0] f,
                                             input logic [31:0] st, input logic [31:0] ca);
        bit irq_line;
        irq_line = 1'b0;
        for (int i = 8; i < 16; i++)
            if (st[i] && ca[i]) irq_line = 1'b1;
        if (!valid)                        return C_NONE;
        if (irq_line && st[0] && !st[1])   return C_INT;
        if (f[4])                          return C_ILL;
        if (f[3])                          return C_OVF;
        if (f[2])                          return C_TRAP;
        if (f[1])                          return C_SYS;
        if (f[0])                          return C_ERET;
        return C_NONE;
    endfunction

    function automatic logic [98:0] observe();
        return {bus.busy, bus.stall, bus.flush, bus.cp0_exception, bus.cp0_pc, bus.redirect_pc};
    endfunction

    task automatic set_flags(input logic [4:0] f);
        bus.exc_illegal  = f[4];
        bus.exc_overflow = f[3];
        bus.exc_trap     = f[2];
        bus.exc_syscall  = f[1];
        bus.exc_eret     = f[0];
    endtask

    task automatic clear_inputs();
        bus.mem_valid   = 1'b0;
        bus.mem_pc      = '0;
        set_flags(5'b0);
        bus.mem_drained = 1'b0;
        bus.cp0_status  = '0;
        bus.cp0_cause   = '0;
        bus.cp0_epc     = '0;
    endtask

    // One complete request: drives the request, random ignored traffic while busy, and
    // compares every cycle against the expected phase sequence. drain_at = DRAIN cycle
    // in which mem_drained rises (0 = never).
    task automatic run_txn(input string name, input logic valid, input logic [4:0] f,
                           input logic [31:0] pc, input logic [31:0] st, input logic [31:0] ca,
                           input logic [31:0] epc, input int drain_at);
        logic [31:0] code, vec;
        logic [98:0] got, exp;
        int n, pulses;
        code = ref_code(valid, f, st, ca);
        n    = (drain_at == 0 || drain_at > DRAIN_MAX) ? DRAIN_MAX : drain_at;
        vec  = (code == C_ERET) ? epc : (st[22] ? V_BOOT : V_NORMAL);

        @(posedge clk); #1;
        bus.mem_valid   = valid;
        bus.mem_pc      = pc;
        set_flags(f);
        bus.mem_drained = 1'b0;
        bus.cp0_status  = st;
        bus.cp0_cause   = ca;
        bus.cp0_epc     = epc;
        @(negedge clk);
        got = observe();
        exp = {1'b0, (code != C_NONE), 1'b0, 96'd0};
        checks++;
        if (got !== exp) $display("FAIL %s accept: got %h expected %h", name, got, exp);
        else passes++;

        if (code == C_NONE) begin
            @(posedge clk); #1;
            bus.mem_valid = 1'b0;
            set_flags(5'b0);
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0) $display("FAIL %s stays_idle: busy got %b expected 0", name, bus.busy);
            else passes++;
            return;
        end

        pulses = 0;
        for (int i = 1; i <= n + 3; i++) begin
            @(posedge clk); #1;
            if (i <= n + 1) begin
                bus.mem_valid = 1'($urandom);
                set_flags(5'($urandom));
                bus.mem_pc    = $urandom;
            end else begin
                bus.mem_valid = 1'b0;
                set_flags(5'b0);
            end
            bus.mem_drained = (drain_at != 0) && (i >= drain_at);
            @(negedge clk);
            if (bus.cp0_exception !== 32'd0) pulses++;
            if (i <= n)          exp = {1'b1, 1'b1, 1'b0, 96'd0};
            else if (i == n + 1) exp = {1'b1, 1'b1, 1'b0, code, pc, 32'd0};
            else if (i == n + 2) exp = {1'b1, 1'b1, 1'b1, 32'd0, 32'd0, vec};
            else                 exp = {1'b0, 1'b0, 1'b0, 96'd0};
            got = observe();
            checks++;
            if (got !== exp) $display("FAIL %s cycle %0d: got %h expected %h", name, i, got, exp);
            else passes++;
        end
        checks++;
        if (pulses != 1) $display("FAIL %s pulse_count: got %0d expected 1", name, pulses);
        else passes++;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.mem_valid   = 1'b1;
        bus.exc_syscall = 1'b1;
        rst_n = 1'b0;
        #12;
        checks++;
        if (observe() !== 99'd0) $display("FAIL reset_outputs: got %h expected 0", observe());
        else passes++;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_syscall();
        run_txn("syscall", 1'b1, 5'b00010, 32'h400, 32'h0, 32'h0, 32'h0, 1);
    endtask

    task automatic test_priority();
        run_txn("prio_ill", 1'b1, 5'b11010, 32'h1000, 32'h0, 32'h0, 32'h0, 3);
        run_txn("prio_ovf", 1'b1, 5'b01111, 32'h1004, 32'h0, 32'h0, 32'h0, 2);
        run_txn("prio_trap", 1'b1, 5'b00111, 32'h1008, 32'h0, 32'h0, 32'h0, 1);
        run_txn("prio_eret", 1'b1, 5'b00001, 32'h100C, 32'h0, 32'h0, 32'h5550, 2);
        run_txn("no_valid", 1'b0, 5'b11111, 32'h1010, 32'h0, 32'h0, 32'h0, 1);
        run_txn("no_request", 1'b1, 5'b00000, 32'h1014, 32'h401, 32'h0, 32'h0, 1);
    endtask

    task automatic test_interrupt();
        run_txn("irq_wins", 1'b1, 5'b00100, 32'h2000, 32'h0000_0401, 32'h0000_0400, 32'h0, 2);
        run_txn("irq_exl", 1'b1, 5'b00100, 32'h2004, 32'h0000_0403, 32'h0000_0400, 32'h0, 2);
        run_txn("irq_masked", 1'b1, 5'b00000, 32'h2008, 32'h0000_0801, 32'h0000_0400, 32'h0, 2);
    endtask

    task automatic test_drain_timeout();
        run_txn("drain_max", 1'b1, 5'b00010, 32'h3000, 32'h0, 32'h0, 32'h0, 0);
        run_txn("drain_late", 1'b1, 5'b01000, 32'h3004, 32'h0, 32'h0, 32'h0, 15);
    endtask

    task automatic test_eret_boot();
        run_txn("eret_epc", 1'b1, 5'b00001, 32'h4000, 32'h0040_0000, 32'h0, 32'h1234, 2);
        run_txn("trap_boot", 1'b1, 5'b00100, 32'h4004, 32'h0040_0000, 32'h0, 32'h1234, 2);
    endtask

    task automatic test_reset_mid_drain();
        int pulses;
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_pc    = 32'h5000;
        set_flags(5'b00010);
        bus.cp0_status = '0;
        bus.cp0_cause  = '0;
        bus.mem_drained = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (observe() !== 99'd0) $display("FAIL reset_mid_drain: got %h expected 0", observe());
        else passes++;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cp0_exception !== 32'd0 || bus.busy !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) $display("FAIL post_reset_quiet: got %0d active cycles expected 0", pulses);
        else passes++;
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_a", 1'b1, 5'b00010, 32'h6000, 32'h0, 32'h0, 32'h0, 1);
        run_txn("b2b_b", 1'b1, 5'b10000, 32'h6004, 32'h0, 32'h0, 32'h0, 1);
    endtask

    task automatic test_random();
        logic [31:0] st, ca;
        logic [4:0]  f;
        for (int k = 0; k < 40; k++) begin
            st = $urandom;
            st[0] = ($urandom_range(0, 3) != 0);
            st[1] = ($urandom_range(0, 3) == 0);
            ca = $urandom_range(0, 1) ? $urandom : 32'd0;
            f  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_txn("random", ($urandom_range(0, 7) != 0), f, {$urandom, 2'b00} >> 2 << 2,
                    st, ca, $urandom, $urandom_range(0, 17));
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_syscall();
        test_priority();
        test_interrupt();
        test_drain_timeout();
        test_eret_boot();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
